// File: rtl/snitch_icache_refill_handler.sv
// L1 instruction cache refill handler: forwards hits, tracks and coalesces
// misses in a small pending table, and writes refilled lines back to the RAMs.
module snitch_icache_refill_handler #(
    parameter int unsigned FETCH_AW    = 32,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned LINE_ALIGN  = 4,
    parameter int unsigned COUNT_ALIGN = 5,
    parameter int unsigned WAY_COUNT   = 2,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned PENDING     = 2,
    localparam int unsigned SET_ALIGN  = (WAY_COUNT > 2) ? $clog2(WAY_COUNT) : 1,
    localparam int unsigned PID_W      = (PENDING > 2) ? $clog2(PENDING) : 1,
    localparam int unsigned TAG_WIDTH  = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [FETCH_AW-1:0]    in_addr_i,
    input  logic [ID_WIDTH-1:0]    in_id_i,
    input  logic                   in_hit_i,
    input  logic [LINE_WIDTH-1:0]  in_data_i,
    input  logic                   in_error_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [LINE_WIDTH-1:0]  rsp_data_o,
    output logic                   rsp_error_o,
    output logic [ID_WIDTH-1:0]    rsp_id_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [FETCH_AW-1:0]    refill_addr_o,
    output logic [PID_W-1:0]       refill_pid_o,
    output logic                   refill_valid_o,
    input  logic                   refill_ready_i,
    input  logic [LINE_WIDTH-1:0]  refill_data_i,
    input  logic                   refill_error_i,
    input  logic [PID_W-1:0]       refill_pid_i,
    input  logic                   refill_rvalid_i,
    output logic                   refill_rready_o,
    output logic [COUNT_ALIGN-1:0] write_addr_o,
    output logic [SET_ALIGN-1:0]   write_set_o,
    output logic [TAG_WIDTH-1:0]   write_tag_o,
    output logic [LINE_WIDTH-1:0]  write_data_o,
    output logic                   write_error_o,
    output logic                   write_valid_o,
    input  logic                   write_ready_i
);

    localparam int unsigned LAW = FETCH_AW - LINE_ALIGN;

    logic [PENDING-1:0]               pend_valid_q;
    logic [PENDING-1:0][LAW-1:0]      pend_addr_q;
    logic [PENDING-1:0][ID_WIDTH-1:0] pend_id_q;

    logic             refill_valid_q;
    logic [LAW-1:0]   refill_addr_q;
    logic [PID_W-1:0] refill_pid_q;
    logic [SET_ALIGN-1:0] victim_q;

    logic [LAW-1:0]   in_line;
    logic [LAW-1:0]   rsp_line;
    logic             match;
    logic             has_free;
    logic             can_alloc;
    logic [PID_W-1:0] match_idx;
    logic [PID_W-1:0] free_idx;
    logic             refill_fire;
    logic             miss_fire;
    logic             unused_addr;

    assign in_line     = in_addr_i[FETCH_AW-1:LINE_ALIGN];
    assign unused_addr = ^in_addr_i[LINE_ALIGN-1:0];

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        has_free  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < PENDING; i++) begin
            if (pend_valid_q[i] && pend_addr_q[i] == in_line) begin
                match     = 1'b1;
                match_idx = PID_W'(i);
            end
        end
        // Descending scan so the lowest free index wins.
        for (int i = PENDING - 1; i >= 0; i--) begin
            if (!pend_valid_q[i]) begin
                has_free = 1'b1;
                free_idx = PID_W'(i);
            end
        end
    end

    assign can_alloc = has_free & ~refill_valid_q;
    assign rsp_line  = pend_addr_q[refill_pid_i];

    always_comb begin
        rsp_valid_o     = 1'b0;
        rsp_id_o        = in_id_i;
        rsp_data_o      = in_data_i;
        rsp_error_o     = in_error_i;
        write_valid_o   = 1'b0;
        in_ready_o      = 1'b0;
        refill_rready_o = rsp_ready_i & write_ready_i;
        if (refill_rvalid_i) begin
            rsp_valid_o   = 1'b1;
            write_valid_o = 1'b1;
            rsp_id_o      = pend_id_q[refill_pid_i];
            rsp_data_o    = refill_data_i;
            rsp_error_o   = refill_error_i;
        end else if (in_hit_i) begin
            rsp_valid_o = in_valid_i;
            in_ready_o  = rsp_ready_i;
        end else begin
            in_ready_o = match | can_alloc;
        end
    end

    assign write_data_o  = refill_data_i;
    assign write_error_o = refill_error_i;
    assign write_addr_o  = rsp_line[COUNT_ALIGN-1:0];
    assign write_tag_o   = rsp_line[LAW-1:COUNT_ALIGN];
    assign write_set_o   = victim_q;

    assign refill_valid_o = refill_valid_q;
    assign refill_addr_o  = {refill_addr_q, {LINE_ALIGN{1'b0}}};
    assign refill_pid_o   = refill_pid_q;

    assign refill_fire = refill_rvalid_i & refill_rready_o;
    assign miss_fire   = in_valid_i & in_ready_o & ~in_hit_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q   <= '0;
            pend_addr_q    <= '0;
            pend_id_q      <= '0;
            refill_valid_q <= 1'b0;
            refill_addr_q  <= '0;
            refill_pid_q   <= '0;
            victim_q       <= '0;
        end else begin
            if (refill_fire) begin
                pend_valid_q[refill_pid_i] <= 1'b0;
                if (victim_q == SET_ALIGN'(WAY_COUNT - 1)) begin
                    victim_q <= '0;
                end else begin
                    victim_q <= victim_q + 1'b1;
                end
            end
            if (refill_valid_q && refill_ready_i) begin
                refill_valid_q <= 1'b0;
            end
            // Misses never fire alongside a refill response.
            if (miss_fire) begin
                if (match) begin
                    pend_id_q[match_idx] <= pend_id_q[match_idx] | in_id_i;
                end else begin
                    pend_valid_q[free_idx] <= 1'b1;
                    pend_addr_q[free_idx]  <= in_line;
                    pend_id_q[free_idx]    <= in_id_i;
                    refill_valid_q         <= 1'b1;
                    refill_addr_q          <= in_line;
                    refill_pid_q           <= free_idx;
                end
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        refill_rvalid_i |-> pend_valid_q[refill_pid_i]);

endmodule

// File: tb/tb_snitch_icache_refill_handler.sv
// Directed bench for the icache refill handler: hits, misses, coalescing,
// full table, response priority, backpressure and refill errors.
module tb_snitch_icache_refill_handler;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [31:0]  in_addr_i;
    logic [3:0]   in_id_i;
    logic         in_hit_i;
    logic [127:0] in_data_i;
    logic         in_error_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] rsp_data_o;
    logic         rsp_error_o;
    logic [3:0]   rsp_id_o;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  refill_addr_o;
    logic [0:0]   refill_pid_o;
    logic         refill_valid_o;
    logic         refill_ready_i;
    logic [127:0] refill_data_i;
    logic         refill_error_i;
    logic [0:0]   refill_pid_i;
    logic         refill_rvalid_i;
    logic         refill_rready_o;
    logic [4:0]   write_addr_o;
    logic [0:0]   write_set_o;
    logic [22:0]  write_tag_o;
    logic [127:0] write_data_o;
    logic         write_error_o;
    logic         write_valid_o;
    logic         write_ready_i;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [127:0] D_HIT = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222;
    localparam logic [127:0] R1 = 128'hAAAA_0001_AAAA_0001_AAAA_0001_AAAA_0001;
    localparam logic [127:0] R2 = 128'hBBBB_0002_BBBB_0002_BBBB_0002_BBBB_0002;
    localparam logic [127:0] R3 = 128'hCCCC_0003_CCCC_0003_CCCC_0003_CCCC_0003;

    snitch_icache_refill_handler dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_addr_i(in_addr_i), .in_id_i(in_id_i), .in_hit_i(in_hit_i),
        .in_data_i(in_data_i), .in_error_i(in_error_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
        .rsp_id_o(rsp_id_o), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .refill_addr_o(refill_addr_o), .refill_pid_o(refill_pid_o),
        .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
        .refill_data_i(refill_data_i), .refill_error_i(refill_error_i),
        .refill_pid_i(refill_pid_i), .refill_rvalid_i(refill_rvalid_i),
        .refill_rready_o(refill_rready_o),
        .write_addr_o(write_addr_o), .write_set_o(write_set_o),
        .write_tag_o(write_tag_o), .write_data_o(write_data_o),
        .write_error_o(write_error_o), .write_valid_o(write_valid_o),
        .write_ready_i(write_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        in_addr_i = '0; in_id_i = '0; in_hit_i = 0;
        in_data_i = '0; in_error_i = 0; in_valid_i = 0;
        rsp_ready_i = 0; refill_ready_i = 0;
        refill_data_i = '0; refill_error_i = 0;
        refill_pid_i = '0; refill_rvalid_i = 0;
        write_ready_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic miss(input logic [31:0] a, input logic [3:0] id);
        in_valid_i = 1; in_hit_i = 0; in_addr_i = a; in_id_i = id;
    endtask

    task automatic respond(input logic [0:0] pid, input logic [127:0] d, input logic e);
        refill_rvalid_i = 1; refill_pid_i = pid;
        refill_data_i = d; refill_error_i = e;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        #1;
        n_chk++; if (refill_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_refill_valid: got %b want 0", refill_valid_o); end
        n_chk++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        n_chk++; if (write_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_write_valid: got %b want 0", write_valid_o); end
        n_chk++; if (refill_rready_o !== 1'b0) begin n_fail++; $display("FAIL reset_refill_rready: got %b want 0", refill_rready_o); end
        tick();
        tick();
        rst_ni = 1;
        tick();
        n_chk++; if (refill_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_refill_valid: got %b want 0", refill_valid_o); end
    endtask

    task automatic test_hit();
        in_valid_i = 1; in_hit_i = 1; in_id_i = 4'b0010;
        in_data_i = D_HIT; in_addr_i = 32'h0000_4000; rsp_ready_i = 1;
        #1;
        n_chk++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL hit_valid: got %b want 1", rsp_valid_o); end
        n_chk++; if (rsp_id_o !== 4'b0010) begin n_fail++; $display("FAIL hit_id: got %b want 0010", rsp_id_o); end
        n_chk++; if (rsp_data_o !== D_HIT) begin n_fail++; $display("FAIL hit_data: got %h want %h", rsp_data_o, D_HIT); end
        n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL hit_in_ready: got %b want 1", in_ready_o); end
        n_chk++; if (write_valid_o !== 1'b0) begin n_fail++; $display("FAIL hit_no_write: got %b want 0", write_valid_o); end
        rsp_ready_i = 0;
        #1;
        n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL hit_stall_ready: got %b want 0", in_ready_o); end
        n_chk++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL hit_stall_valid: got %b want 1", rsp_valid_o); end
        tick();
        idle();
    endtask

    task automatic test_miss();
        miss(32'h0000_1000, 4'b0001);
        #1;
        n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL miss_in_ready: got %b want 1", in_ready_o); end
        n_chk++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_no_rsp: got %b want 0", rsp_valid_o); end
        tick();
        in_valid_i = 0;
        #1;
        n_chk++; if (refill_valid_o !== 1'b1) begin n_fail++; $display("FAIL miss_refill_valid: got %b want 1", refill_valid_o); end
        n_chk++; if (refill_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL miss_refill_addr: got %h want 00001000", refill_addr_o); end
        n_chk++; if (refill_pid_o !== 1'b0) begin n_fail++; $display("FAIL miss_refill_pid: got %b want 0", refill_pid_o); end
        refill_ready_i = 1;
        tick();
        refill_ready_i = 0;
        #1;
        n_chk++; if (refill_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_refill_drop: got %b want 0", refill_valid_o); end
        respond(1'b0, R1, 1'b0);
        rsp_ready_i = 1; write_ready_i = 1;
        #1;
        n_chk++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL miss_rsp_valid: got %b want 1", rsp_valid_o); end
        n_chk++; if (rsp_id_o !== 4'b0001) begin n_fail++; $display("FAIL miss_rsp_id: got %b want 0001", rsp_id_o); end
        n_chk++; if (rsp_data_o !== R1) begin n_fail++; $display("FAIL miss_rsp_data: got %h want %h", rsp_data_o, R1); end
        n_chk++; if (write_valid_o !== 1'b1) begin n_fail++; $display("FAIL miss_write_valid: got %b want 1", write_valid_o); end
        n_chk++; if (write_data_o !== R1) begin n_fail++; $display("FAIL miss_write_data: got %h want %h", write_data_o, R1); end
        n_chk++; if (write_addr_o !== 5'd0) begin n_fail++; $display("FAIL miss_write_addr: got %0d want 0", write_addr_o); end
        n_chk++; if (write_tag_o !== 23'h8) begin n_fail++; $display("FAIL miss_write_tag: got %h want 8", write_tag_o); end
        n_chk++; if (write_set_o !== 1'b0) begin n_fail++; $display("FAIL miss_write_set: got %b want 0", write_set_o); end
        n_chk++; if (refill_rready_o !== 1'b1) begin n_fail++; $display("FAIL miss_rready: got %b want 1", refill_rready_o); end
        n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL miss_rsp_in_ready: got %b want 0", in_ready_o); end
        tick();
        idle();
        #1;
        n_chk++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_rsp_done: got %b want 0", rsp_valid_o); end
    endtask

    task automatic test_coalesce();
        tick();
        miss(32'h0000_1000, 4'b0001);
        tick();
        miss(32'h0000_1004, 4'b0100);
        #1;
        n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL coal_in_ready: got %b want 1", in_ready_o); end
        n_chk++; if (refill_valid_o !== 1'b1) begin n_fail++; $display("FAIL coal_refill_valid: got %b want 1", refill_valid_o); end
        refill_ready_i = 1;
        tick();
        in_valid_i = 0; refill_ready_i = 0;
        #1;
        n_chk++; if (refill_valid_o !== 1'b0) begin n_fail++; $display("FAIL coal_single_refill: got %b want 0", refill_valid_o); end
        tick();
        n_chk++; if (refill_valid_o !== 1'b0) begin n_fail++; $display("FAIL coal_no_second: got %b want 0", refill_valid_o); end
        respond(1'b0, R2, 1'b0);
        rsp_ready_i = 1; write_ready_i = 1;
        #1;
        n_chk++; if (rsp_id_o !== 4'b0101) begin n_fail++; $display("FAIL coal_rsp_id: got %b want 0101", rsp_id_o); end
        n_chk++; if (write_set_o !== 1'b1) begin n_fail++; $display("FAIL coal_write_set: got %b want 1", write_set_o); end
        tick();
        idle();
    endtask

    task automatic test_full_priority();
        tick();
        miss(32'h0000_1000, 4'b0001);
        tick();
        in_valid_i = 0; refill_ready_i = 1;
        #1;
        n_chk++; if (refill_pid_o !== 1'b0) begin n_fail++; $display("FAIL full_pid0: got %b want 0", refill_pid_o); end
        tick();
        refill_ready_i = 0;
        miss(32'h0000_2000, 4'b0010);
        #1;
        n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_alloc1: got %b want 1", in_ready_o); end
        tick();
        in_valid_i = 0; refill_ready_i = 1;
        #1;
        n_chk++; if (refill_pid_o !== 1'b1) begin n_fail++; $display("FAIL full_pid1: got %b want 1", refill_pid_o); end
        n_chk++; if (refill_addr_o !== 32'h0000_2000) begin n_fail++; $display("FAIL full_addr1: got %h want 00002000", refill_addr_o); end
        tick();
        refill_ready_i = 0;
        miss(32'h0000_3054, 4'b0100);
        #1;
        n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %b want 0", in_ready_o); end
        tick();
        n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_stall2: got %b want 0", in_ready_o); end
        respond(1'b0, R1, 1'b0);
        rsp_ready_i = 1; write_ready_i = 1;
        #1;
        n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_rsp_block: got %b want 0", in_ready_o); end
        n_chk++; if (rsp_id_o !== 4'b0001) begin n_fail++; $display("FAIL full_rsp_id0: got %b want 0001", rsp_id_o); end
        n_chk++; if (write_set_o !== 1'b0) begin n_fail++; $display("FAIL full_set0: got %b want 0", write_set_o); end
        tick();
        refill_rvalid_i = 0;
        #1;
        n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_freed: got %b want 1", in_ready_o); end
        tick();
        in_valid_i = 0;
        #1;
        n_chk++; if (refill_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_realloc_valid: got %b want 1", refill_valid_o); end
        n_chk++; if (refill_pid_o !== 1'b0) begin n_fail++; $display("FAIL full_realloc_pid: got %b want 0", refill_pid_o); end
        n_chk++; if (refill_addr_o !== 32'h0000_3050) begin n_fail++; $display("FAIL full_realloc_addr: got %h want 00003050", refill_addr_o); end
        refill_ready_i = 1;
        tick();
        refill_ready_i = 0;
        respond(1'b1, R2, 1'b1);
        rsp_ready_i = 0;
        #1;
        n_chk++; if (refill_rready_o !== 1'b0) begin n_fail++; $display("FAIL bp_rready: got %b want 0", refill_rready_o); end
        n_chk++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid_o); end
        tick();
        refill_rvalid_i = 0; rsp_ready_i = 1;
        miss(32'h0000_2008, 4'b1000);
        #1;
        n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_coalesce_full: got %b want 1", in_ready_o); end
        tick();
        in_valid_i = 0;
        respond(1'b1, R2, 1'b1);
        #1;
        n_chk++; if (rsp_id_o !== 4'b1010) begin n_fail++; $display("FAIL err_rsp_id: got %b want 1010", rsp_id_o); end
        n_chk++; if (rsp_error_o !== 1'b1) begin n_fail++; $display("FAIL err_rsp_error: got %b want 1", rsp_error_o); end
        n_chk++; if (write_error_o !== 1'b1) begin n_fail++; $display("FAIL err_write_error: got %b want 1", write_error_o); end
        n_chk++; if (write_set_o !== 1'b1) begin n_fail++; $display("FAIL err_write_set: got %b want 1", write_set_o); end
        n_chk++; if (write_tag_o !== 23'h10) begin n_fail++; $display("FAIL err_write_tag: got %h want 10", write_tag_o); end
        n_chk++; if (refill_rready_o !== 1'b1) begin n_fail++; $display("FAIL err_rready: got %b want 1", refill_rready_o); end
        tick();
        refill_rvalid_i = 0; refill_error_i = 0;
        in_valid_i = 1; in_hit_i = 1; in_id_i = 4'b1000;
        in_data_i = D_HIT; in_addr_i = 32'h0000_5000;
        respond(1'b0, R3, 1'b0);
        #1;
        n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL prio_in_ready: got %b want 0", in_ready_o); end
        n_chk++; if (rsp_id_o !== 4'b0100) begin n_fail++; $display("FAIL prio_rsp_id: got %b want 0100", rsp_id_o); end
        n_chk++; if (rsp_data_o !== R3) begin n_fail++; $display("FAIL prio_rsp_data: got %h want %h", rsp_data_o, R3); end
        n_chk++; if (write_addr_o !== 5'd5) begin n_fail++; $display("FAIL prio_write_addr: got %0d want 5", write_addr_o); end
        n_chk++; if (write_tag_o !== 23'h18) begin n_fail++; $display("FAIL prio_write_tag: got %h want 18", write_tag_o); end
        n_chk++; if (write_set_o !== 1'b0) begin n_fail++; $display("FAIL prio_write_set: got %b want 0", write_set_o); end
        tick();
        refill_rvalid_i = 0;
        #1;
        n_chk++; if (rsp_id_o !== 4'b1000) begin n_fail++; $display("FAIL prio_hit_id: got %b want 1000", rsp_id_o); end
        n_chk++; if (rsp_data_o !== D_HIT) begin n_fail++; $display("FAIL prio_hit_data: got %h want %h", rsp_data_o, D_HIT); end
        n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL prio_hit_ready: got %b want 1", in_ready_o); end
        n_chk++; if (write_valid_o !== 1'b0) begin n_fail++; $display("FAIL prio_hit_no_write: got %b want 0", write_valid_o); end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_coalesce();
        test_full_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
